// File: rtl/pipe_core.sv
// Four-stage (F/D/E/W) in-order core with a small ALU ISA, E/W operand forwarding,
// an externally loaded instruction memory and a run/pause/drain/halt controller.
module pipe_core #(
  parameter int DATA_W  = 32,
  parameter int NREG    = 16,
  parameter int IMEM_AW = 9
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [IMEM_AW-1:0]      addr,
  input  logic                    wEn,
  input  logic [31:0]             wDat,
  input  logic                    working,
  input  logic [$clog2(NREG)-1:0] rID,
  output logic [DATA_W-1:0]       rdata,
  output logic                    halted,
  output logic                    illegal,
  output logic [15:0]             retired
);

  localparam int          RW       = $clog2(NREG);
  localparam logic [31:0] NOP_WORD = 32'h0100_0000;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;
  typedef enum logic [2:0] {OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_XOR} op_t;

  logic [31:0]       imem [2**IMEM_AW];
  logic [DATA_W-1:0] regs [NREG];

  state_t            state, state_nxt;
  logic [IMEM_AW-1:0] pc;

  logic              d_valid;
  logic [31:0]       d_ir;

  logic              e_valid;
  op_t               e_op;
  logic [RW-1:0]     e_dst;
  logic [DATA_W-1:0] e_a, e_b, e_result;

  logic              w_valid;
  logic [RW-1:0]     w_dst;
  logic [DATA_W-1:0] w_result;

  logic [RW-1:0]     d_ra, d_rb;
  logic [DATA_W-1:0] d_valc;
  logic              d_halt, d_write, d_bad;
  op_t               d_op;
  logic [RW-1:0]     d_dst;
  logic [DATA_W-1:0] op_a, op_b;
  logic              advance, fetch;

  assign d_ra   = d_ir[20 +: RW];
  assign d_rb   = d_ir[16 +: RW];
  assign d_valc = DATA_W'(d_ir[15:0]);

  // Only instructions that write a register travel down the pipe as valid;
  // HALT, NOP and undefined encodings leave a bubble behind them.
  always_comb begin
    d_halt  = 1'b0;
    d_write = 1'b0;
    d_bad   = 1'b0;
    d_op    = OP_ADD;
    d_dst   = d_ra;
    if (d_valid) begin
      case (d_ir[31:24])
        8'h00: d_halt = 1'b1;
        8'h01: ;
        8'h10: begin d_write = 1'b1; d_op = OP_MOV; d_dst = d_rb; end
        8'h20: begin d_write = 1'b1; d_op = OP_ADD; end
        8'h21: begin d_write = 1'b1; d_op = OP_SUB; end
        8'h32: begin d_write = 1'b1; d_op = OP_AND; end
        8'h33: begin d_write = 1'b1; d_op = OP_XOR; end
        default: d_bad = 1'b1;
      endcase
    end
  end

  // Youngest producer wins: E overrides W, W overrides the register file.
  always_comb begin
    op_a = regs[d_ra];
    if (e_valid && e_dst == d_ra)      op_a = e_result;
    else if (w_valid && w_dst == d_ra) op_a = w_result;
    op_b = regs[d_rb];
    if (e_valid && e_dst == d_rb)      op_b = e_result;
    else if (w_valid && w_dst == d_rb) op_b = w_result;
  end

  always_comb begin
    e_result = e_b;
    case (e_op)
      OP_MOV:  e_result = e_b;
      OP_ADD:  e_result = e_a + e_b;
      OP_SUB:  e_result = e_a - e_b;
      OP_AND:  e_result = e_a & e_b;
      OP_XOR:  e_result = e_a ^ e_b;
      default: e_result = e_b;
    endcase
  end

  // DRAIN keeps flushing older work even if working drops; RUN pauses on it.
  assign advance = (state == S_RUN && working) || (state == S_DRAIN);
  assign fetch   = (state == S_RUN) && working && !d_halt;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (working) state_nxt = S_RUN;
      S_RUN:    if (working && d_halt) state_nxt = S_DRAIN;
      S_DRAIN:  if (!e_valid && !w_valid) state_nxt = S_HALTED;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the instruction memory has no reset so it can map onto a RAM macro
  // and keep its program across reset.
  always_ff @(posedge clock) begin
    if (wEn && !working) imem[addr] <= wDat;
  end

  // NOTE: the register file is reset explicitly (a loop over all entries) since
  // software relies on every register reading 0 after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= '0;
      d_valid  <= 1'b0;
      d_ir     <= NOP_WORD;
      e_valid  <= 1'b0;
      e_op     <= OP_ADD;
      e_dst    <= '0;
      e_a      <= '0;
      e_b      <= '0;
      w_valid  <= 1'b0;
      w_dst    <= '0;
      w_result <= '0;
      illegal  <= 1'b0;
      retired  <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (advance) begin
      if (fetch) begin
        d_ir    <= imem[pc];
        d_valid <= 1'b1;
        pc      <= pc + IMEM_AW'(1);
      end else begin
        d_ir    <= NOP_WORD;
        d_valid <= 1'b0;
      end
      e_valid  <= d_write;
      e_op     <= d_op;
      e_dst    <= d_dst;
      e_a      <= op_a;
      e_b      <= (d_op == OP_MOV) ? d_valc : op_b;
      w_valid  <= e_valid;
      w_dst    <= e_dst;
      w_result <= e_result;
      if (w_valid) begin
        regs[w_dst] <= w_result;
        if (retired != 16'hFFFF) retired <= retired + 16'd1;
      end
      if (d_bad) illegal <= 1'b1;
    end
  end

  assign rdata  = regs[rID];
  assign halted = (state == S_HALTED);

endmodule

// File: tb/tb_pipe_core.sv
// Randomized and directed bench for pipe_core; final state is compared against
// a sequential instruction-set interpreter.
module tb_pipe_core;

  logic        clock = 1'b0;
  logic        reset;
  logic [8:0]  addr;
  logic        wEn;
  logic [31:0] wDat;
  logic        working;
  logic [3:0]  rID;
  logic [31:0] rdata;
  logic        halted, illegal;
  logic [15:0] retired;

  int total = 0;
  int bad   = 0;

  logic [31:0] mreg [16];
  int          mret;
  logic        mill;
  logic [31:0] prog [$];

  pipe_core dut (
    .clock(clock), .reset(reset), .addr(addr), .wEn(wEn), .wDat(wDat),
    .working(working), .rID(rID), .rdata(rdata), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] ic, input logic [3:0] fn,
                                      input logic [3:0] ra, input logic [3:0] rb,
                                      input logic [15:0] vc);
    return {ic, fn, ra, rb, vc};
  endfunction

  // Architectural interpreter: one instruction at a time, no pipeline notion.
  task automatic model_run(input logic [31:0] p[$]);
    int pcm = 0;
    for (int i = 0; i < 16; i++) mreg[i] = 0;
    mret = 0;
    mill = 1'b0;
    for (int step = 0; step < 4096; step++) begin
      logic [31:0] w = p[pcm];
      logic [3:0]  ra = w[23:20], rb = w[19:16];
      if (w[31:24] == 8'h00) break;
      case (w[31:24])
        8'h01: ;
        8'h10: begin mreg[rb] = {16'h0, w[15:0]};     mret++; end
        8'h20: begin mreg[ra] = mreg[ra] + mreg[rb];  mret++; end
        8'h21: begin mreg[ra] = mreg[ra] - mreg[rb];  mret++; end
        8'h32: begin mreg[ra] = mreg[ra] & mreg[rb];  mret++; end
        8'h33: begin mreg[ra] = mreg[ra] ^ mreg[rb];  mret++; end
        default: mill = 1'b1;
      endcase
      pcm = (pcm + 1) % 512;
    end
  endtask

  task automatic write_word(input int a, input logic [31:0] d);
    working = 1'b0;
    addr = a[8:0];
    wDat = d;
    wEn  = 1'b1;
    @(posedge clock); #1;
    wEn  = 1'b0;
  endtask

  task automatic load_prog(input logic [31:0] p[$]);
    foreach (p[i]) write_word(i, p[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    working = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // mode 0: continuous, 1: 5-cycle pause at pause_at, 2: random pauses
  task automatic run_core(input string tag, input int mode, input int pause_at);
    int cyc = 0;
    while (!halted && cyc < 3000) begin
      case (mode)
        1:       working = !(cyc >= pause_at && cyc < pause_at + 5);
        2:       working = ($urandom_range(0, 3) != 0);
        default: working = 1'b1;
      endcase
      @(posedge clock); #1;
      cyc++;
    end
    working = 1'b0;
    check({tag, "_halted"}, halted, 1);
  endtask

  task automatic check_state(input string tag);
    @(negedge clock);
    for (int r = 0; r < 16; r++) begin
      rID = r[3:0];
      #1 check($sformatf("%s_r%0d", tag, r), rdata, mreg[r]);
    end
    check({tag, "_retired"}, retired, mret);
    check({tag, "_illegal"}, illegal, mill);
  endtask

  task automatic prog_029();
    prog.delete();
    prog.push_back(enc(1, 0, 4'hF, 1, 16'd5));
    prog.push_back(enc(1, 0, 4'hF, 2, 16'd3));
    prog.push_back(enc(2, 0, 1, 2, 16'd0));
    prog.push_back(enc(0, 0, 0, 0, 16'd0));
  endtask

  task automatic read_reg(input int r, output logic [31:0] v);
    @(negedge clock);
    rID = r[3:0];
    #1 v = rdata;
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1; working = 1'b0; wEn = 1'b0; addr = '0; wDat = '0; rID = '0;
    repeat (3) @(posedge clock); #1;

    // reset state
    @(negedge clock);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_retired", retired, 0);
    for (int r = 0; r < 16; r++) begin
      rID = r[3:0];
      #1 check($sformatf("rst_r%0d", r), rdata, 0);
    end
    reset = 1'b0;

    // basic program
    prog_029();
    load_prog(prog);
    do_reset();
    run_core("p029", 0, 0);
    read_reg(1, v); check("p029_r1_is_8", v, 32'd8);
    read_reg(2, v); check("p029_r2_is_3", v, 32'd3);
    check("p029_retired_3", retired, 16'd3);
    model_run(prog);
    check_state("p029");

    // back-to-back dependences, forwarding
    prog.delete();
    prog.push_back(enc(1, 0, 4'hF, 1, 16'd1));
    prog.push_back(enc(2, 1, 1, 1, 16'd0));
    prog.push_back(enc(1, 0, 4'hF, 3, 16'hFFFF));
    prog.push_back(enc(1, 0, 4'hF, 4, 16'hFFFF));
    prog.push_back(enc(2, 0, 3, 4, 16'd0));
    prog.push_back(enc(0, 0, 0, 0, 16'd0));
    load_prog(prog);
    do_reset();
    run_core("p030", 0, 0);
    read_reg(3, v); check("p030_r3", v, 32'h0001_FFFE);
    read_reg(1, v); check("p030_r1", v, 32'd0);
    model_run(prog);
    check_state("p030");

    // same program with a 5-cycle pause mid-stream
    do_reset();
    run_core("p033", 1, 4);
    check_state("p033");

    // subtraction wrap
    prog.delete();
    prog.push_back(enc(1, 0, 4'hF, 0, 16'd0));
    prog.push_back(enc(1, 0, 4'hF, 5, 16'd1));
    prog.push_back(enc(2, 1, 0, 5, 16'd0));
    prog.push_back(enc(0, 0, 0, 0, 16'd0));
    load_prog(prog);
    do_reset();
    run_core("p031", 0, 0);
    read_reg(0, v); check("p031_r0", v, 32'hFFFF_FFFF);

    // undefined opcode
    prog.delete();
    prog.push_back(enc(1, 0, 4'hF, 1, 16'd5));
    prog.push_back(32'h7000_0000);
    prog.push_back(enc(1, 0, 4'hF, 2, 16'd3));
    prog.push_back(enc(0, 0, 0, 0, 16'd0));
    load_prog(prog);
    do_reset();
    run_core("p032", 0, 0);
    check("p032_illegal", illegal, 1);
    check("p032_retired", retired, 16'd2);
    model_run(prog);
    check_state("p032");

    // reset with ADD in E, then rerun
    prog_029();
    load_prog(prog);
    do_reset();
    working = 1'b1;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1; working = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("p034_halted", halted, 0);
    check("p034_retired", retired, 0);
    for (int r = 0; r < 16; r++) begin
      rID = r[3:0];
      #1 check($sformatf("p034_r%0d", r), rdata, 0);
    end
    run_core("p034_rerun", 0, 0);
    model_run(prog);
    check_state("p034_rerun");

    // pc wrap: word 0 is rewritten during a pause so the second pass ends
    write_word(0, enc(1, 0, 4'hF, 6, 16'd1));
    for (int i = 1; i < 511; i++) write_word(i, 32'h0100_0000);
    write_word(511, enc(1, 0, 4'hF, 7, 16'h1234));
    do_reset();
    working = 1'b1;
    repeat (20) @(posedge clock);
    #1 working = 1'b0;
    write_word(0, enc(2, 0, 6, 6, 16'd0));
    write_word(1, enc(0, 0, 0, 0, 16'd0));
    run_core("wrap", 0, 0);
    read_reg(6, v); check("wrap_r6", v, 32'd2);
    read_reg(7, v); check("wrap_r7", v, 32'h1234);
    check("wrap_retired", retired, 16'd3);

    // random programs with random pauses
    for (int t = 0; t < 8; t++) begin
      int len = $urandom_range(12, 30);
      prog.delete();
      for (int i = 0; i < len; i++) begin
        logic [3:0] ra = 4'($urandom_range(0, 15));
        logic [3:0] rb = 4'($urandom_range(0, 15));
        logic [15:0] vc = 16'($urandom);
        case ($urandom_range(0, 11))
          0, 1, 2: prog.push_back(enc(1, 0, ra, rb, vc));
          3, 4:    prog.push_back(enc(2, 0, ra, rb, vc));
          5, 6:    prog.push_back(enc(2, 1, ra, rb, vc));
          7:       prog.push_back(enc(3, 2, ra, rb, vc));
          8:       prog.push_back(enc(3, 3, ra, rb, vc));
          9:       prog.push_back(enc(0, 1, ra, rb, vc));
          10:      prog.push_back(enc(4'($urandom_range(4, 15)), 4'($urandom), ra, rb, vc));
          default: prog.push_back(enc(2, 4'($urandom_range(2, 15)), ra, rb, vc));
        endcase
      end
      prog.push_back(enc(0, 0, 0, 0, 16'd0));
      load_prog(prog);
      do_reset();
      run_core($sformatf("rnd%0d", t), 2, 0);
      model_run(prog);
      check_state($sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
